gray_wptr_ctrl: RTL

- Write-side pointer controller for a dual-clock FIFO. It is the encoding end of the Gray-pointer crossing; the read side decodes.
- Holds the binary write pointer and drives the RAM write address and write enable.
- Publishes a registered, glitch-free Gray copy of the pointer for synchronisation into the read domain.
- Derives full, fill level and a sticky overflow flag from the read pointer. That pointer arrives already synchronised, in Gray code.

---
 rtl/gray_wptr_ctrl_pkg.sv | 33 +++
 rtl/gray_wptr_ctrl_if.sv | 25 ++
 rtl/gray_wptr_ctrl_gray_decode.sv | 11 +
 rtl/gray_wptr_ctrl_gray_encode.sv | 9 +
 rtl/gray_wptr_ctrl.sv | 63 ++++++
 5 files changed

// File: rtl/gray_wptr_ctrl_pkg.sv
// Pointer helpers shared by both ends of the Gray-pointer crossing.
// Width-generic via a 32-bit carrier; callers zero-extend and truncate.
package gray_wptr_ctrl_pkg;

    localparam int PTR_MAX = 32;
    typedef logic [PTR_MAX-1:0] ptr_t;

    function automatic ptr_t bin2gray(ptr_t b);
        return b ^ (b >> 1);
    endfunction

    // Prefix XOR from the MSB down; zero upper bits leave the result unaffected.
    function automatic ptr_t gray2bin(ptr_t g);
        ptr_t b;
        b = '0;
        b[PTR_MAX-1] = g[PTR_MAX-1];
        for (int i = PTR_MAX - 2; i >= 0; i--) begin
            b[i] = b[i+1] ^ g[i];
        end
        return b;
    endfunction

    // Full when the top two bits differ and the rest match over an n-bit pointer.
    // The read side uses the same compare for empty by checking all-equal.
    function automatic logic ptr_full(ptr_t wg, ptr_t rg, int n);
        ptr_t mask;
        ptr_t top;
        mask = (ptr_t'(1) << n) - ptr_t'(1);
        top  = ptr_t'(3) << (n - 2);
        return ((wg ^ rg) & mask) == top;
    endfunction

endpackage

// File: rtl/gray_wptr_ctrl_if.sv
// Producer-facing bundle of the write-side pointer controller.
interface gray_wptr_ctrl_if #(
    parameter int W_ADDR = 4
);
    // push is a request held by the producer; it is accepted on the clk edge
    // where wen = push & ~full is high, and refused (setting overflow) otherwise.
    logic              push;
    logic [W_ADDR:0]   rptr_gray;
    logic              wen;
    logic [W_ADDR-1:0] waddr;
    logic [W_ADDR:0]   wptr_gray;
    logic              full;
    logic [W_ADDR:0]   level;
    logic              overflow;

    modport master (
        output push, rptr_gray,
        input  wen, waddr, wptr_gray, full, level, overflow
    );

    modport slave (
        input  push, rptr_gray,
        output wen, waddr, wptr_gray, full, level, overflow
    );
endinterface

// File: rtl/gray_wptr_ctrl_gray_decode.sv
// Combinational Gray-to-binary decoder for the synchronised read pointer.
module gray_wptr_ctrl_gray_decode
    import gray_wptr_ctrl_pkg::*;
#(
    parameter int N = 5
) (
    input  logic [N-1:0] g,
    output logic [N-1:0] b
);
    assign b = N'(gray2bin(ptr_t'(g)));
endmodule

// File: rtl/gray_wptr_ctrl_gray_encode.sv
// Combinational binary-to-Gray encoder feeding the wptr_gray flops.
module gray_wptr_ctrl_gray_encode #(
    parameter int N = 5
) (
    input  logic [N-1:0] i,
    output logic [N-1:0] o
);
    assign o = i ^ (i >> 1);
endmodule

// File: rtl/gray_wptr_ctrl.sv
// Write-side pointer controller: binary write pointer, registered Gray copy,
// and full / level / sticky overflow derived from the synchronised read pointer.
module gray_wptr_ctrl
    import gray_wptr_ctrl_pkg::*;
#(
    parameter int W_ADDR = 4
) (
    input  logic           clk,
    input  logic           rst,
    gray_wptr_ctrl_if.slave bus
);
    localparam int PTR_W = W_ADDR + 1;

    logic [PTR_W-1:0] wptr_bin;
    logic [PTR_W-1:0] wptr_gray_q;
    logic [PTR_W-1:0] wptr_next;
    logic [PTR_W-1:0] gray_next;
    logic [PTR_W-1:0] rptr_bin;
    logic             overflow_q;
    logic             full_c;
    logic             wen_c;

    assign wptr_next = wptr_bin + PTR_W'(1);

    gray_wptr_ctrl_gray_encode #(.N(PTR_W)) u_encode (
        .i (wptr_next),
        .o (gray_next)
    );

    gray_wptr_ctrl_gray_decode #(.N(PTR_W)) u_decode (
        .g (bus.rptr_gray),
        .b (rptr_bin)
    );

    // full compares the registered Gray pointer, so the published pointer and
    // the full decision always agree; a lagging rptr_gray only makes it pessimistic.
    assign full_c = ptr_full(ptr_t'(wptr_gray_q), ptr_t'(bus.rptr_gray), PTR_W);
    assign wen_c  = bus.push & ~full_c;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wptr_bin    <= '0;
            wptr_gray_q <= '0;
            overflow_q  <= 1'b0;
        end else begin
            if (wen_c) begin
                wptr_bin    <= wptr_next;
                wptr_gray_q <= gray_next;
            end
            if (bus.push & full_c) begin
                overflow_q <= 1'b1;
            end
        end
    end

    assign bus.wen       = wen_c;
    assign bus.waddr     = wptr_bin[W_ADDR-1:0];
    assign bus.wptr_gray = wptr_gray_q;
    assign bus.full      = full_c;
    assign bus.level     = wptr_bin - rptr_bin;
    assign bus.overflow  = overflow_q;

endmodule
